// File: rtl/spi_regbridge.sv
// spi_regbridge
// SPI-slave (mode 0, MSB first) front end for the Maple register file.
// Turns each SPI frame into a 7-bit register number plus one-cycle read/write
// strobes, and shifts register read data back out on MISO.
//
// Frame format: a header byte {wr, regnum[6:0]} followed by any number of
// data bytes.
//   - Write frames (wr = 1): every data byte pulses write.
//   - Read frames (wr = 0): every data byte shifts out regdata_read,
//     prefetched one byte ahead.
// Burst accesses never auto-increment regnum.
//
// Ports
//   clk, rst_n     system clock, async active-low reset
//   ss, sck, mosi  raw SPI pins (asynchronous to clk)
//   miso           serial read data (tri-stated by the parent)
//   regnum         register number of the current/last frame
//   regdata_read   read data for regnum (combinational in the parent)
//   regdata_write  last received write byte
//   read           1-clk pulse: a read byte has started shifting out
//   write          1-clk pulse: regdata_write valid for regnum
//
// state   | meaning
// IDLE    | ss deasserted, waiting for a frame
// HEADER  | receiving the header byte, MISO shifts zeros
// DATA_WR | receiving write data bytes
// DATA_RD | shifting prefetched read bytes out on MISO
module spi_regbridge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ss,
  input  logic       sck,
  input  logic       mosi,
  output logic       miso,
  output logic [6:0] regnum,
  input  logic [7:0] regdata_read,
  output logic [7:0] regdata_write,
  output logic       read,
  output logic       write
);

  typedef enum logic [1:0] {IDLE, HEADER, DATA_WR, DATA_RD} state_t;

  logic [SYNC_STAGES-1:0] sck_sync_q, sck_sync_d;
  logic [SYNC_STAGES-1:0] ss_sync_q, ss_sync_d;
  logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
  logic                   sck_prev_q, sck_prev_d;

  state_t     state_q, state_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] rx_shift_q, rx_shift_d;
  logic [7:0] tx_shift_q, tx_shift_d;
  logic [6:0] regnum_q, regnum_d;
  logic [7:0] regdata_write_q, regdata_write_d;
  logic       read_q, read_d;
  logic       write_q, write_d;
  logic       byte_done_q, byte_done_d;
  logic       load_pend_q, load_pend_d;

  logic sck_s, ss_s, mosi_s;
  logic sck_rise, sck_fall;

  assign sck_s  = sck_sync_q[SYNC_STAGES-1];
  assign ss_s   = ss_sync_q[SYNC_STAGES-1];
  assign mosi_s = mosi_sync_q[SYNC_STAGES-1];

  assign sck_rise = sck_s & ~sck_prev_q;
  assign sck_fall = ~sck_s & sck_prev_q;

  always_comb begin
    sck_sync_d  = {sck_sync_q[SYNC_STAGES-2:0], sck};
    ss_sync_d   = {ss_sync_q[SYNC_STAGES-2:0], ss};
    mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], mosi};
    sck_prev_d  = sck_s;
  end

  always_comb begin
    state_d         = state_q;
    bit_cnt_d       = bit_cnt_q;
    rx_shift_d      = rx_shift_q;
    tx_shift_d      = tx_shift_q;
    regnum_d        = regnum_q;
    regdata_write_d = regdata_write_q;
    read_d          = 1'b0;
    write_d         = 1'b0;
    byte_done_d     = 1'b0;
    load_pend_d     = 1'b0;

    if (ss_s) begin
      // Deselect wins over everything: a partial or just-completed byte is
      // dropped and any pending prefetch is cancelled.
      state_d   = IDLE;
      bit_cnt_d = 3'd0;
    end else if (state_q == IDLE) begin
      state_d    = HEADER;
      bit_cnt_d  = 3'd0;
      tx_shift_d = 8'h00;
    end else begin
      if (sck_rise) begin
        rx_shift_d = {rx_shift_q[6:0], mosi_s};
        bit_cnt_d  = bit_cnt_q + 3'd1;
        if (bit_cnt_q == 3'd7) begin
          byte_done_d = 1'b1;
        end
        // First bit of a read byte: that byte is now committed to the host.
        if (state_q == DATA_RD && bit_cnt_q == 3'd0) begin
          read_d = 1'b1;
        end
      end

      // Falling edge right after a byte boundary keeps the freshly loaded MSB.
      if (sck_fall && bit_cnt_q != 3'd0) begin
        tx_shift_d = {tx_shift_q[6:0], 1'b0};
      end

      // Prefetch one cycle after byte completion so regdata_read already
      // reflects an updated regnum.
      if (load_pend_q) begin
        tx_shift_d = regdata_read;
      end

      if (byte_done_q) begin
        case (state_q)
          HEADER: begin
            regnum_d = rx_shift_q[6:0];
            if (rx_shift_q[7]) begin
              state_d = DATA_WR;
            end else begin
              state_d     = DATA_RD;
              load_pend_d = 1'b1;
            end
          end
          DATA_WR: begin
            regdata_write_d = rx_shift_q;
            write_d         = 1'b1;
          end
          DATA_RD: begin
            load_pend_d = 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sck_sync_q      <= '0;
      ss_sync_q       <= '1;
      mosi_sync_q     <= '0;
      sck_prev_q      <= 1'b0;
      state_q         <= IDLE;
      bit_cnt_q       <= 3'd0;
      rx_shift_q      <= 8'h00;
      tx_shift_q      <= 8'h00;
      regnum_q        <= 7'd0;
      regdata_write_q <= 8'h00;
      read_q          <= 1'b0;
      write_q         <= 1'b0;
      byte_done_q     <= 1'b0;
      load_pend_q     <= 1'b0;
    end else begin
      sck_sync_q      <= sck_sync_d;
      ss_sync_q       <= ss_sync_d;
      mosi_sync_q     <= mosi_sync_d;
      sck_prev_q      <= sck_prev_d;
      state_q         <= state_d;
      bit_cnt_q       <= bit_cnt_d;
      rx_shift_q      <= rx_shift_d;
      tx_shift_q      <= tx_shift_d;
      regnum_q        <= regnum_d;
      regdata_write_q <= regdata_write_d;
      read_q          <= read_d;
      write_q         <= write_d;
      byte_done_q     <= byte_done_d;
      load_pend_q     <= load_pend_d;
    end
  end

  assign miso          = tx_shift_q[7];
  assign regnum        = regnum_q;
  assign regdata_write = regdata_write_q;
  assign read          = read_q;
  assign write         = write_q;

endmodule
